cycle_averager: RTL and testbench
=================================

# cycle_averager

Coherent cycle averager placed directly downstream of the DAC/LUT sample source. It locks to the source's zero-cross marker and accumulates 2^k consecutive signal cycles of M points each, point by point, into an internal RAM. It then streams out the averaged single cycle, one point per clock. This gives a noise-reduced reference or loopback waveform for the lock-in and analysis stages.

## Interface
- MAX_PTS, 2048, maximum points per cycle and RAM depth.
- IN_W, 16, significant input sample width; taken from data[15:0].
- MAX_K, 8, maximum log2 of the cycle count.
- ACC_W, 24, accumulator width, equal to IN_W+MAX_K.
- clock  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- sample_en  in  1  one-cycle new-sample strobe, tied to the source clock enable.
- data_valid  in  1  source data valid; may stay high continuously.
- data  in  32  source sample; bits [31:16] are ignored.
- zero_cross  in  1  source cycle-start marker.
- ptos_x_ciclo  in  16  points per cycle M; sampled on start.
- log2_ciclos  in  4  k, so N=2^k cycles are averaged; sampled on start.
- start  in  1  one-cycle request to begin an acquisition.
- busy  out  1  high from an accepted start until done.
- cfg_err  out  1  sticky; set by a start with bad configuration, cleared by the next accepted start.
- out_valid  out  1  averaged point valid, one clock per point.
- out_index  out  16  point index of out_data.
- out_data  out  32  averaged point, {zero-extend, acc>>k}.
- out_last  out  1  marks point M-1.
- done  out  1  one-clock pulse after the last point.

## Operation
- Accepted sample strobe: acc_in = sample_en & data_valid.
- IDLE: start with 2<=M<=MAX_PTS and k<=MAX_K latches M and k, then goes to ARM with busy=1.
  - Any other start sets cfg_err and stays in IDLE.
  - start is ignored whenever busy=1.
- ARM: waits for acc_in & zero_cross & !zero_cross_d, where zero_cross_d is the previous-clock register of zero_cross.
  - The sample accepted in that cycle is point 0 of cycle 0.
  - The state then goes to ACCUM.
- ACCUM: each acc_in processes point idx of cycle cyc.
  - cyc==0: RAM[idx] <= sample. The first cycle overwrites, so stale RAM needs no clear.
  - cyc>0: RAM[idx] <= RAM[idx] + sample.
  - idx wraps from M-1 to 0 and increments cyc.
  - The state goes to DUMP after the sample at idx=M-1, cyc=N-1 is written.
  - zero_cross is not re-checked in ACCUM; the source period is trusted to equal M.
- DUMP: reads addresses 0..M-1 on consecutive clocks.
  - Each point is output as out_data = RAM[i] >> k.
  - done is pulsed after the last point, then the state returns to IDLE with busy=0.
- Width rules: samples are unsigned, and sums cannot overflow because 2^MAX_K * (2^IN_W - 1) < 2^ACC_W. The shift is logical and truncating.
- k=0: a single cycle is passed through unchanged.

## Timing
- RAM is simple dual-port with a synchronous 1-clock read.
  - A sample accepted at clock t reads RAM[idx] at t and writes at t+1.
  - Back-to-back acc_in is supported. M>=2 guarantees no same-address read-after-write hazard.
- Entry to DUMP occurs at t+2 after the final sample at t.
  - First out_valid is 2 clocks after DUMP entry.
  - There are then M consecutive out_valid clocks.
  - done is high the clock after out_last; busy falls with done.
- Acquisition latency from the ARM trigger: N*M accepted samples, plus 4+M clocks to done.
- Reset values: busy=0, cfg_err=0, out_valid=0, out_index=0, out_data=0, out_last=0, done=0, state IDLE, idx=cyc=0.
- Asynchronous reset mid-operation aborts at once with no done. RAM contents are don't-care.
- Simultaneous start and zero_cross in IDLE: start is accepted; arming begins on the next clock, so that edge is missed.
- acc_in outside ARM/ACCUM is ignored. Samples arriving during DUMP are dropped.

## Structure
- cycle_avg_pkg holds:
  - state enum {IDLE, ARM, ACCUM, DUMP};
  - MAX_PTS, MAX_K, IN_W, ACC_W;
  - the address width clog2(MAX_PTS).
- Sub-module acc_ram: parameterised ACC_W x MAX_PTS simple dual-port RAM with registered read, inferable as block RAM.
- The FSM, counters and output pipeline are in cycle_averager.

## Test plan
- M=8, k=2, constant data=100, continuous sample_en: 8 outputs of 100, out_index 0..7, out_last on index 7, done one clock after.
- M=4, k=1, cycle 0 = {0,10,20,30}, cycle 1 = {2,12,22,32}: outputs {1,11,21,31}, truncated by the shift.
- M=16, k=8, data=16'hFFFF: every output is 16'hFFFF with no overflow.
- sample_en every 3rd clock, zero_cross held high from before start: no trigger until the next rising edge. Results are identical to the continuous-strobe case.
- M=1 or k=9 start: cfg_err=1, busy stays 0. A following valid start clears cfg_err.
- reset_n pulsed low mid-ACCUM: all outputs 0 and no done. A new start then produces correct averages, with no stale RAM contribution.

Source files
------------

// File: rtl/cycle_avg_pkg.sv
// Shared types and sizing for the coherent cycle averager.
package cycle_avg_pkg;

    localparam int MAX_PTS = 2048;
    localparam int IN_W    = 16;
    localparam int MAX_K   = 8;
    localparam int ACC_W   = IN_W + MAX_K;
    localparam int ADDR_W  = $clog2(MAX_PTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2,
        DUMP  = 2'd3
    } state_t;

    // A start is legal only for 2..MAX_PTS points and at most 2^MAX_K cycles.
    function automatic logic cfg_ok(input logic [15:0] m, input logic [3:0] k);
        return (m >= 16'd2) && (m <= 16'(MAX_PTS)) && (k <= 4'(MAX_K));
    endfunction

endpackage

// File: rtl/cycle_averager_acc_ram.sv
// Simple dual-port accumulator RAM with a registered read port (block-RAM style).
module acc_ram #(
    parameter int DW    = 24,
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; contents are not reset.
    always_ff @(posedge clock) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cycle_averager.sv
// Coherent cycle averager: sums 2^k source cycles point-wise in RAM, then streams the mean cycle.
module cycle_averager
    import cycle_avg_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sample_en,
    input  logic        data_valid,
    input  logic [31:0] data,
    input  logic        zero_cross,
    input  logic [15:0] ptos_x_ciclo,
    input  logic [3:0]  log2_ciclos,
    input  logic        start,
    output logic        busy,
    output logic        cfg_err,
    output logic        out_valid,
    output logic [15:0] out_index,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        done
);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     m_q, m_d;
    logic [3:0]          k_q, k_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [MAX_K-1:0]    cyc_q, cyc_d;
    logic                fin_q, fin_d;
    logic                cfg_err_q, cfg_err_d;
    logic                zc_q, busy_q;

    logic                acc_in_s, trig_s, take_s, dump_rd_s, ram_re_s;
    logic                idx_last_s, cyc_last_s;
    logic [ADDR_W:0]     m_m1_s;
    logic [MAX_K:0]      n_m1_s;

    logic                wr_pend_q, wr_first_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [IN_W-1:0]     wr_sample_q;
    logic [ACC_W-1:0]    ram_wdata_s, ram_rdata_s;

    logic                rd_pend_q, rd_last_q;
    logic [ADDR_W-1:0]   rd_idx_q;

    logic                out_valid_q, out_last_q, done_q;
    logic [15:0]         out_index_q;
    logic [31:0]         out_data_q;

    logic                unused_s;
    assign unused_s = ^data[31:16];

    assign acc_in_s   = sample_en & data_valid;
    assign trig_s     = acc_in_s & zero_cross & ~zc_q;
    assign m_m1_s     = m_q - (ADDR_W+1)'(1);
    assign n_m1_s     = ((MAX_K+1)'(1) << k_q) - (MAX_K+1)'(1);
    assign idx_last_s = ({1'b0, idx_q} == m_m1_s);
    assign cyc_last_s = ({1'b0, cyc_q} == n_m1_s);

    // Next-state logic; fin_q marks "final sample taken" in ACCUM and "reads issued" in DUMP.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        k_d       = k_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        fin_d     = fin_q;
        cfg_err_d = cfg_err_q;
        take_s    = 1'b0;
        dump_rd_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok(ptos_x_ciclo, log2_ciclos)) begin
                    m_d       = ptos_x_ciclo[ADDR_W:0];
                    k_d       = log2_ciclos;
                    cfg_err_d = 1'b0;
                    idx_d     = '0;
                    cyc_d     = '0;
                    fin_d     = 1'b0;
                    state_d   = ARM;
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                take_s = trig_s;
            end
            ACCUM: begin
                if (fin_q) begin
                    fin_d   = 1'b0;
                    idx_d   = '0;
                    state_d = DUMP;
                end else begin
                    take_s = acc_in_s;
                end
            end
            DUMP: begin
                if (!fin_q) begin
                    dump_rd_s = 1'b1;
                    if (idx_last_s) begin
                        fin_d = 1'b1;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end else begin
                    fin_d = fin_q;
                end
                if (out_last_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DUMP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take_s) begin
            state_d = ACCUM;
            if (idx_last_s) begin
                idx_d = '0;
                if (cyc_last_s) begin
                    fin_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + MAX_K'(1);
                end
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end else begin
            cyc_d = cyc_d;
        end
    end

    assign ram_re_s = take_s | dump_rd_s;

    // First cycle overwrites stale RAM; later cycles add onto the value read one clock earlier.
    always_comb begin
        if (wr_first_q) begin
            ram_wdata_s = {{MAX_K{1'b0}}, wr_sample_q};
        end else begin
            ram_wdata_s = ram_rdata_s + {{MAX_K{1'b0}}, wr_sample_q};
        end
    end

    acc_ram #(
        .DW    (ACC_W),
        .DEPTH (MAX_PTS),
        .AW    (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (wr_pend_q),
        .waddr (wr_addr_q),
        .wdata (ram_wdata_s),
        .re    (ram_re_s),
        .raddr (idx_q),
        .rdata (ram_rdata_s)
    );

    // Control state, write pipeline, read pipeline and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            cyc_q       <= '0;
            fin_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
            zc_q        <= 1'b0;
            busy_q      <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_first_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_sample_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= 16'd0;
            out_data_q  <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            cyc_q       <= cyc_d;
            fin_q       <= fin_d;
            cfg_err_q   <= cfg_err_d;
            zc_q        <= zero_cross;
            busy_q      <= (state_d != IDLE);
            wr_pend_q   <= take_s;
            wr_first_q  <= (cyc_q == '0);
            wr_addr_q   <= idx_q;
            wr_sample_q <= data[IN_W-1:0];
            rd_pend_q   <= dump_rd_s;
            rd_last_q   <= dump_rd_s & idx_last_s;
            rd_idx_q    <= idx_q;
            out_valid_q <= rd_pend_q;
            out_last_q  <= rd_pend_q & rd_last_q;
            done_q      <= out_last_q;
            if (rd_pend_q) begin
                out_index_q <= {{(16-ADDR_W){1'b0}}, rd_idx_q};
                out_data_q  <= {{(32-ACC_W){1'b0}}, ram_rdata_s >> k_q};
            end
        end
    end

    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cycle_averager.sv
// Directed self-checking bench for cycle_averager with an arithmetic averaging model.
module tb_cycle_averager;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sample_en, data_valid, zero_cross, start;
    logic [31:0] data;
    logic [15:0] ptos_x_ciclo;
    logic [3:0]  log2_ciclos;
    logic        busy, cfg_err, out_valid, out_last, done;
    logic [15:0] out_index;
    logic [31:0] out_data;

    int checks = 0;
    int passes = 0;
    int exp_q[$];
    int exp_idx = 0;
    int cur_m = 0;
    int done_cnt = 0;
    int cap [0:2047];
    bit prev_last = 1'b0;

    always #5 clock = ~clock;

    cycle_averager dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_en    (sample_en),
        .data_valid   (data_valid),
        .data         (data),
        .zero_cross   (zero_cross),
        .ptos_x_ciclo (ptos_x_ciclo),
        .log2_ciclos  (log2_ciclos),
        .start        (start),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .out_valid    (out_valid),
        .out_index    (out_index),
        .out_data     (out_data),
        .out_last     (out_last),
        .done         (done)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Sample value of point i in cycle c for each stimulus pattern.
    function automatic int val(input int mode, input int c, input int i);
        case (mode)
            0: return 100;
            1: return i * 10 + 2 * c;
            2: return 16'hFFFF;
            default: return (c * 37 + i * 101) & 16'hFFFF;
        endcase
    endfunction

    // Output checker: every valid point must match the model queue in order.
    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    chk("out_index", out_index, exp_idx);
                    chk("out_last", out_last, (exp_idx == cur_m - 1) ? 1 : 0);
                    cap[exp_idx] = int'(out_data);
                    exp_idx++;
                end
            end
            if (done) begin
                chk("done_after_last", prev_last, 1);
                chk("busy_low_at_done", busy, 0);
                done_cnt++;
            end
            prev_last = out_last;
        end else begin
            prev_last = 1'b0;
        end
    end

    task automatic do_start(input int m, input int k);
        @(posedge clock); #1;
        ptos_x_ciclo = 16'(m);
        log2_ciclos  = 4'(k);
        start        = 1'b1;
        @(posedge clock); #1;
        start        = 1'b0;
    endtask

    // Stream 2^k cycles of m points with one accepted strobe every 'stride' clocks, then await done.
    task automatic feed(input int m, input int k, input int mode, input int stride);
        int n, sum, cnt;
        bit got;
        n = 1 << k;
        cur_m = m;
        exp_idx = 0;
        for (int i = 0; i < m; i++) begin
            sum = 0;
            for (int c = 0; c < n; c++) sum += val(mode, c, i);
            exp_q.push_back(sum >> k);
        end
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < m; i++) begin
                for (int g = 0; g < stride - 1; g++) begin
                    @(posedge clock); #1;
                    sample_en  = 1'b1;
                    data_valid = 1'b0;
                    data       = $urandom;
                    zero_cross = 1'b0;
                end
                @(posedge clock); #1;
                sample_en  = 1'b1;
                data_valid = 1'b1;
                data       = {16'($urandom), 16'(val(mode, c, i))};
                zero_cross = (i == 0);
            end
        end
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < m + 20) begin
            @(posedge clock); #1;
            sample_en  = 1'b0;
            data_valid = 1'b0;
            zero_cross = 1'b0;
            cnt++;
            if (done) got = 1'b1;
        end
        chk("done_latency", got ? cnt : -1, m + 4);
        chk("all_points_out", exp_q.size(), 0);
        @(posedge clock); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        reset_n = 1'b0; sample_en = 1'b0; data_valid = 1'b0; zero_cross = 1'b0;
        start = 1'b0; data = 32'd0; ptos_x_ciclo = 16'd0; log2_ciclos = 4'd0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);

        // Constant 100, continuous strobe; a bad start while busy is ignored.
        do_start(8, 2);
        chk("busy_after_start", busy, 1);
        do_start(1, 2);
        chk("start_ignored_when_busy", cfg_err, 0);
        feed(8, 2, 0, 1);
        chk("t1_point0", cap[0], 100);
        chk("t1_point7", cap[7], 100);

        // Truncating average of two cycles.
        do_start(4, 1);
        feed(4, 1, 1, 1);
        chk("t2_p0", cap[0], 1);
        chk("t2_p1", cap[1], 11);
        chk("t2_p2", cap[2], 21);
        chk("t2_p3", cap[3], 31);

        // Full-scale input at the maximum cycle count.
        do_start(16, 8);
        feed(16, 8, 2, 1);
        chk("t3_p0_fullscale", cap[0], 16'hFFFF);
        chk("t3_p15_fullscale", cap[15], 16'hFFFF);

        // zero_cross already high at start: no trigger until the next rising edge.
        zero_cross = 1'b1;
        do_start(8, 2);
        for (int j = 0; j < 3; j++) begin
            @(posedge clock); #1;
            sample_en = 1'b1; data_valid = 1'b1; data = 32'd9999;
        end
        @(posedge clock); #1;
        sample_en = 1'b0; data_valid = 1'b0; zero_cross = 1'b0;
        @(posedge clock); #1;
        feed(8, 2, 0, 3);
        chk("t4_p0_strided", cap[0], 100);
        chk("t4_p7_strided", cap[7], 100);

        // Configuration errors, then a valid k=0 pass-through start.
        do_start(1, 2);
        chk("cfg_err_m1", cfg_err, 1);
        chk("busy_m1", busy, 0);
        do_start(8, 9);
        chk("cfg_err_k9", cfg_err, 1);
        chk("busy_k9", busy, 0);
        do_start(5, 0);
        chk("cfg_err_cleared", cfg_err, 0);
        chk("busy_valid_start", busy, 1);
        feed(5, 0, 3, 1);
        chk("t5_p2_passthru", cap[2], 202);

        // Reset in the middle of accumulation.
        do_start(8, 2);
        for (int j = 0; j < 12; j++) begin
            @(posedge clock); #1;
            sample_en = 1'b1; data_valid = 1'b1;
            data = 32'd5000; zero_cross = (j == 0);
        end
        @(posedge clock); #1;
        reset_n = 1'b0;
        sample_en = 1'b0; data_valid = 1'b0; zero_cross = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_done", done, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        dc = done_cnt;
        repeat (20) @(posedge clock);
        #1;
        chk("no_done_after_abort", done_cnt, dc);
        do_start(8, 1);
        feed(8, 1, 3, 1);
        chk("t6_p3_fresh", cap[3], 321);

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
